// File: rtl/perf_counter_unit.sv
// -----------------------------------------------------------------------------
// perf_counter_unit
//
// Purpose:
//   Performance counter block. Holds NUM_EVT event counters and one free
//   running cycle counter. All counters advance while the unit is in RUN.
//   A halt strobe freezes them, and only a clear returns the unit to RUN.
//   Counters either wrap or saturate, selected by SAT_MODE. Each counter has a
//   sticky overflow flag. One read port returns the value of any counter.
//
// Parameters:
//   NUM_EVT  - number of event channels (inst retired, dcache hit, icache hit,
//              dcache req, icache req with the default of 5)
//   CNT_W    - width of every counter
//   SAT_MODE - 0: counters wrap to zero, 1: counters hold at all-ones
//   SEL_W    - read select width, must satisfy 2**SEL_W >= NUM_EVT+1
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset, overrides all other inputs
//   evt      in   [NUM_EVT]   per-channel event strobes
//   halt     in   processor halt strobe (RUN -> FROZEN)
//   clr      in   synchronous clear of counters and flags (FROZEN -> RUN)
//   rd_en    in   read request
//   rd_sel   in   [SEL_W]     0..NUM_EVT-1 event counter, NUM_EVT cycle counter
//   rd_data  out  [CNT_W]     registered read data
//   rd_valid out  rd_data qualifier
//   frozen   out  high while the state is FROZEN
//   ovf      out  [NUM_EVT+1] sticky overflow flags, MSB = cycle counter
//   dbgState out  raw state register (0 = RUN, 1 = FROZEN) for checkers
//
// Read handshake:
//   There is no back-pressure, so the port is always ready. A read is accepted
//   on every edge where rd_en=1. The value captured is the selected counter as
//   it stood before that edge's update. On the following cycle rd_valid=1 and
//   rd_data holds that value. After an edge with rd_en=0, rd_valid=0 and
//   rd_data keeps its previous contents. An out-of-range select returns zero
//   with rd_valid=1.
// -----------------------------------------------------------------------------
module perf_counter_unit #(
    parameter int NUM_EVT  = 5,
    parameter int CNT_W    = 32,
    parameter int SAT_MODE = 0,
    parameter int SEL_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               halt,
    input  logic               clr,
    input  logic               rd_en,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_valid,
    output logic               frozen,
    output logic [NUM_EVT:0]   ovf,
    output logic               dbgState
);

    // Counters are kept in one array. Index NUM_EVT is the cycle counter, so
    // every counter goes through the same increment, overflow and read logic.
    localparam int NUM_CNT = NUM_EVT + 1;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } stateT;

    stateT state;
    stateT stateNext;

    logic [CNT_W-1:0]   cntReg  [NUM_CNT];
    logic [CNT_W-1:0]   cntNext [NUM_CNT];
    logic [NUM_CNT-1:0] ovfReg;
    logic [NUM_CNT-1:0] ovfNext;
    logic [NUM_CNT-1:0] incReq;
    logic [NUM_CNT-1:0] atMax;
    logic               countEn;
    logic [CNT_W-1:0]   selValue;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Clear beats halt. A clear with halt on the same edge stays in RUN.
    always_comb begin
        stateNext = state;
        case (state)
            RUN: begin
                if (!clr && halt) begin
                    stateNext = FROZEN;
                end
            end
            FROZEN: begin
                if (clr) begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    // The halt edge is still a RUN edge, so it counts. Freezing takes effect
    // on the next edge.
    assign countEn = (state == RUN) && !clr;

    // The cycle counter always requests an increment. Event counters request
    // one only when their strobe is high.
    assign incReq = {1'b1, evt};

    // -------------------------------------------------------------------------
    // Counter next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            atMax[i]   = &cntReg[i];
            cntNext[i] = cntReg[i];
        end
        ovfNext = ovfReg;

        if (clr) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cntNext[i] = '0;
            end
            ovfNext = '0;
        end else if (countEn) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (incReq[i]) begin
                    if (atMax[i]) begin
                        // Both modes flag the overflow. Only wrap mode rolls
                        // the counter over to zero.
                        ovfNext[i] = 1'b1;
                        cntNext[i] = (SAT_MODE != 0) ? cntReg[i] : '0;
                    end else begin
                        cntNext[i] = cntReg[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cntReg[i] <= '0;
            end
            ovfReg <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cntReg[i] <= cntNext[i];
            end
            ovfReg <= ovfNext;
        end
    end

    // -------------------------------------------------------------------------
    // Read port
    // -------------------------------------------------------------------------
    // The mux reads cntReg, not cntNext. A read therefore sees the value from
    // before this edge, including a read on the same edge as a clear.
    always_comb begin
        selValue = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                selValue = cntReg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= selValue;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign frozen   = (state == FROZEN);
    assign dbgState = state;
    assign ovf      = ovfReg;

endmodule

// File: tb/tb_perf_counter_unit.sv
// -----------------------------------------------------------------------------
// tb_perf_counter_unit
//
// Three instances share one stimulus stream:
//   dut0 : default configuration (CNT_W=32, wrap)
//   dut1 : CNT_W=4, wrap
//   dut2 : CNT_W=4, saturate
// The reference model keeps each counter as a plain integer. An increment adds
// one. A result that reaches 2**CNT_W sets the flag and is folded back,
// either wrapped or clipped.
// -----------------------------------------------------------------------------
module tb_perf_counter_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] evt;
    logic       halt;
    logic       clr;
    logic       rd_en;
    logic [2:0] rd_sel;

    logic [31:0] rdData0;
    logic [3:0]  rdData1;
    logic [3:0]  rdData2;
    logic        rdValid0, rdValid1, rdValid2;
    logic        frozen0, frozen1, frozen2;
    logic        dbg0, dbg1, dbg2;
    logic [5:0]  ovf0, ovf1, ovf2;

    perf_counter_unit dut0 (
        .clk(clk), .rst(rst), .evt(evt), .halt(halt), .clr(clr),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rdData0), .rd_valid(rdValid0),
        .frozen(frozen0), .ovf(ovf0), .dbgState(dbg0)
    );

    perf_counter_unit #(.CNT_W(4), .SAT_MODE(0)) dut1 (
        .clk(clk), .rst(rst), .evt(evt), .halt(halt), .clr(clr),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rdData1), .rd_valid(rdValid1),
        .frozen(frozen1), .ovf(ovf1), .dbgState(dbg1)
    );

    perf_counter_unit #(.CNT_W(4), .SAT_MODE(1)) dut2 (
        .clk(clk), .rst(rst), .evt(evt), .halt(halt), .clr(clr),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rdData2), .rd_valid(rdValid2),
        .frozen(frozen2), .ovf(ovf2), .dbgState(dbg2)
    );

    // ---------------- scoreboard / model ----------------
    int vectors     = 0;
    int miscompares = 0;

    int     cw   [3] = '{32, 4, 4};
    bit     satM [3] = '{1'b0, 1'b0, 1'b1};
    longint mCnt [3][6];
    bit     mOvf [3][6];
    longint mRd  [3];
    bit     mFrz;
    bit     mRv;
    logic [31:0] exp_q[$];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] packOvf(input int c);
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = mOvf[c][i];
        return v;
    endfunction

    task automatic modelZero();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 6; i++) begin
                mCnt[c][i] = 0;
                mOvf[c][i] = 1'b0;
            end
        end
        mFrz = 1'b0;
    endtask

    // Applies the inputs sampled on one rising edge to the model.
    task automatic modelEdge();
        longint lim;
        if (rst) begin
            modelZero();
            mRv = 1'b0;
            for (int c = 0; c < 3; c++) mRd[c] = 0;
            exp_q.delete();
        end else begin
            mRv = rd_en;
            if (rd_en) begin
                for (int c = 0; c < 3; c++) mRd[c] = (rd_sel <= 3'd5) ? mCnt[c][rd_sel] : 0;
                exp_q.push_back(32'(mRd[0]));
            end
            if (clr) begin
                modelZero();
            end else if (!mFrz) begin
                for (int c = 0; c < 3; c++) begin
                    lim = longint'(1) << cw[c];
                    for (int i = 0; i < 6; i++) begin
                        if (i == 5 || evt[i]) begin
                            mCnt[c][i] = mCnt[c][i] + 1;
                            if (mCnt[c][i] >= lim) begin
                                mOvf[c][i] = 1'b1;
                                mCnt[c][i] = satM[c] ? lim - 1 : mCnt[c][i] - lim;
                            end
                        end
                    end
                end
                if (halt) mFrz = 1'b1;
            end
        end
    endtask

    task automatic checkDut(input int c, input logic [31:0] rd, input logic rv,
                            input logic fz, input logic db, input logic [5:0] ov);
        checkVal($sformatf("rd_valid%0d", c), rv, mRv);
        checkVal($sformatf("rd_data%0d", c), rd, mRd[c]);
        checkVal($sformatf("frozen%0d", c), fz, mFrz);
        checkVal($sformatf("dbgState%0d", c), db, mFrz);
        checkVal($sformatf("ovf%0d", c), ov, packOvf(c));
    endtask

    task automatic checkAll();
        checkDut(0, rdData0, rdValid0, frozen0, dbg0, ovf0);
        checkDut(1, 32'(rdData1), rdValid1, frozen1, dbg1, ovf1);
        checkDut(2, 32'(rdData2), rdValid2, frozen2, dbg2, ovf2);
        if (mRv) begin
            if (exp_q.size() == 0) checkVal("rd_q_empty", 1, 0);
            else checkVal("rd_q", rdData0, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic setIdle();
        rst = 1'b0; evt = '0; halt = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_sel = '0;
    endtask

    task automatic readSel(input int sel);
        rd_en  = 1'b1;
        rd_sel = 3'(sel);
        tick();
        rd_en  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        modelZero();
        mRv = 1'b0;
        for (int c = 0; c < 3; c++) mRd[c] = 0;

        setIdle();
        rst = 1'b1;
        tick();
        tick();
        checkVal("rst_rd_data", rdData0, 0);
        checkVal("rst_frozen", frozen0, 0);
        checkVal("rst_ovf", ovf0, 0);

        // Ten events on channel 0, then read channel 0 and the cycle counter.
        rst = 1'b0;
        evt = 5'b00001;
        repeat (10) tick();
        evt = '0;
        readSel(0);
        checkVal("basic_ch0", rdData0, 10);
        readSel(5);
        checkVal("basic_cyc", rdData0, 11);

        // The halt edge counts. The edges after it do not.
        halt = 1'b1; evt = 5'b11111;
        tick();
        halt = 1'b0;
        repeat (5) tick();
        evt = '0;
        checkVal("halt_frozen", frozen0, 1);
        readSel(0);
        checkVal("halt_ch0", rdData0, 11);
        readSel(1);
        checkVal("halt_ch1", rdData0, 1);
        readSel(5);
        checkVal("halt_cyc", rdData0, 13);
        readSel(5);
        checkVal("halt_cyc_static", rdData0, 13);

        // A clear wins over halt and evt. A read on the same edge sees the old value.
        clr = 1'b1; halt = 1'b1; evt = 5'b11111; rd_en = 1'b1; rd_sel = 3'd2;
        tick();
        setIdle();
        checkVal("clr_rd_preclear", rdData0, 1);
        checkVal("clr_frozen", frozen0, 0);
        readSel(2);
        checkVal("clr_ch2_zero", rdData0, 0);
        readSel(5);
        checkVal("clr_cyc_restart", rdData0, 1);

        // Narrow counters: 17 events on channel 1.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        evt = 5'b00010;
        repeat (17) tick();
        evt = '0;
        readSel(1);
        checkVal("wrap_ch1", rdData1, 1);
        checkVal("wrap_ovf1", ovf1[1], 1);
        checkVal("sat_ch1", rdData2, 15);
        checkVal("sat_ovf1", ovf2[1], 1);
        checkVal("wide_ch1", rdData0, 17);
        checkVal("wide_ovf1", ovf0[1], 0);

        // Reset while frozen with flags set.
        halt = 1'b1; evt = 5'b11111;
        tick();
        setIdle();
        tick();
        checkVal("pre_rst_frozen", frozen1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkVal("rst2_rd_data", rdData0, 0);
        checkVal("rst2_rd_valid", rdValid0, 0);
        checkVal("rst2_ovf", ovf1, 0);
        checkVal("rst2_frozen", frozen1, 0);
        readSel(5);
        checkVal("rst2_cyc_first", rdData0, 0);
        readSel(5);
        checkVal("rst2_cyc_second", rdData0, 1);

        // An out-of-range select returns zero. Idle cycles drop rd_valid.
        readSel(7);
        checkVal("oor_data", rdData0, 0);
        checkVal("oor_valid", rdValid0, 1);
        tick();
        checkVal("idle_valid", rdValid0, 0);
        checkVal("idle_hold", rdData0, 0);

        // Randomized traffic.
        repeat (3000) begin
            rst    = ($urandom_range(0, 199) == 0);
            clr    = ($urandom_range(0, 49) == 0);
            halt   = ($urandom_range(0, 29) == 0);
            evt    = 5'($urandom);
            rd_en  = 1'($urandom_range(0, 1));
            rd_sel = 3'($urandom_range(0, 7));
            tick();
        end
        setIdle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 SHALL have parameter NUM_EVT, default 5, the number of event channels (order: inst retired, dcache hit, icache hit, dcache req, icache req).
REQ-002 SHALL have parameter CNT_W, default 32, the width of each counter.
REQ-003 SHALL have parameter SAT_MODE, default 0: 0 = counters wrap, 1 = counters saturate at all-ones.
REQ-004 SHALL have parameter SEL_W, default 3, the read-select width; it SHALL satisfy 2^SEL_W >= NUM_EVT+1.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port evt, input, NUM_EVT, per-channel event strobes sampled on posedge clk.
REQ-008 SHALL have port halt, input, 1, processor-halt strobe.
REQ-009 SHALL have port clr, input, 1, synchronous counter clear.
REQ-010 SHALL have port rd_en, input, 1, read request.
REQ-011 SHALL have port rd_sel, input, SEL_W, register index: 0..NUM_EVT-1 = event counters, NUM_EVT = cycle counter.
REQ-012 SHALL have port rd_data, output, CNT_W, registered read data.
REQ-013 SHALL have port rd_valid, output, 1, rd_data qualifier.
REQ-014 SHALL have port frozen, output, 1, high while counting is stopped after halt.
REQ-015 SHALL have port ovf, output, NUM_EVT+1, sticky overflow flags; bit NUM_EVT belongs to the cycle counter.

Function
REQ-016 SHALL use two states: RUN and FROZEN.
REQ-017 SHALL go RUN -> FROZEN on any edge where halt=1 and clr=0.
REQ-018 SHALL go FROZEN -> RUN only on clr=1.
REQ-019 In RUN, SHALL increment the cycle counter by 1 every edge.
REQ-020 In RUN, SHALL increment event counter i by 1 on every edge where evt[i]=1; channels are independent, and any number may increment on the same edge.
REQ-021 The halt edge itself SHALL be counted: counters update with that edge's evt and cycle increment, then freeze.
REQ-022 In FROZEN, SHALL hold all counters and ovf regardless of evt and halt.
REQ-023 Wrap mode (SAT_MODE=0): a counter at 2^CNT_W-1 that increments SHALL become 0 and set its ovf bit.
REQ-024 Saturate mode (SAT_MODE=1): a counter at 2^CNT_W-1 SHALL hold and set its ovf bit when an increment is requested.
REQ-025 ovf bits SHALL stay set until clr or rst.
REQ-026 clr=1 SHALL, on that edge, zero all counters and ovf, enter RUN, and ignore that edge's evt and halt (priority: rst > clr > halt > evt).
REQ-027 rd_en=1 at edge N SHALL give rd_data = the selected counter's value before edge N's update, with rd_valid=1 after edge N (1-cycle latency).
REQ-028 rd_valid SHALL be 0 in any cycle following an edge with rd_en=0; rd_data SHALL then hold its last value.
REQ-029 rd_sel > NUM_EVT with rd_en=1 SHALL return rd_data=0 with rd_valid=1.
REQ-030 Reads SHALL be legal in both states and in the same cycle as clr (return the pre-clear value).
REQ-031 frozen SHALL be 1 exactly when the state is FROZEN.

Reset
REQ-032 rst=1 SHALL, on the edge, zero all counters, ovf, rd_data and rd_valid, set frozen=0, and enter RUN, overriding all other inputs.
REQ-033 rst asserted mid-operation (either state) SHALL behave identically to power-on reset; the first count SHALL occur on the first edge with rst=0.

Verification
REQ-034 Release rst; drive evt=5'b00001 for 10 cycles, then 0; read sel 0 and sel 5 -> 10 and the elapsed cycle count.
REQ-035 Assert halt together with evt=5'b11111 for one cycle, then drive evt=all-ones for 5 more cycles -> every event counter increased by exactly 1, frozen=1, cycle counter static.
REQ-036 CNT_W=4, SAT_MODE=0: 17 events on ch 1 -> count 1, ovf[1]=1; SAT_MODE=1: 17 events -> count 15, ovf[1]=1.
REQ-037 clr, halt, evt=all-ones and rd_en sel 2 in the same cycle -> rd_data = pre-clear count, all counters 0, frozen=0.
REQ-038 Assert rst while FROZEN with nonzero counters and ovf set -> all outputs 0; sel 5 read at the next edge returns 0 (no edges counted before it), and counting resumes on the following edge.
REQ-039 rd_sel=7 with NUM_EVT=5 -> rd_data=0, rd_valid=1; then rd_en=0 -> rd_valid=0.
